lcd_timing_generator: RTL and testbench

//  Generates LCD raster timing (pixel tick, sync, data enable) for the panel.

---
 rtl/lcd_timing_generator.sv | 81 ++++++++
 tb/tb_lcd_timing_generator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_generator.sv
// lcd_timing_generator: LCD raster timing (tick, sync, data enable) and registered panel pixel output.
// Define LCD_TEST_PATTERN_EN to replace streamer pixels with 8 vertical colour bars.
module lcd_timing_generator #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic        lcd_tick,
  output logic        lcd_next_frame,
  output logic        lcd_data_enable,
  input  logic [7:0]  lcd_red,
  input  logic [7:0]  lcd_green,
  input  logic [7:0]  lcd_blue,
  output logic        panel_pclk,
  output logic        panel_hsync_n,
  output logic        panel_vsync_n,
  output logic        panel_de,
  output logic [23:0] panel_rgb
);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  logic        phase;
  logic [10:0] h;
  logic [10:0] v;
  logic        active;
  logic        hs;
  logic        vs;
  logic [23:0] pix;
  assign active          = h < HA && v < VA;
  assign hs              = h >= HS_BEG && h < HS_END;
  assign vs              = v >= VS_BEG && v < VS_END;
  assign lcd_tick        = phase;
  assign lcd_data_enable = active && !reset;
  assign lcd_next_frame  = !reset && !phase && h == '0 && v == VA;
`ifdef LCD_TEST_PATTERN_EN
  logic [2:0] bar;
  logic       unused_pix;
  assign unused_pix = ^{lcd_red, lcd_green, lcd_blue};
  assign bar        = 3'(h / 11'(H_ACTIVE / 8));
  assign pix        = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
`else
  assign pix = {lcd_red, lcd_green, lcd_blue};
`endif
  // panel_pclk is registered so it reads 0 in reset yet equals ~phase afterwards
  always_ff @(posedge clock) begin
    if (reset) begin
      phase         <= 1'b0;
      h             <= '0;
      v             <= '0;
      panel_pclk    <= 1'b0;
      panel_hsync_n <= 1'b1;
      panel_vsync_n <= 1'b1;
      panel_de      <= 1'b0;
      panel_rgb     <= '0;
    end else begin
      phase         <= ~phase;
      panel_pclk    <= phase;
      if (phase) begin
        h <= h == H_LAST ? '0 : h + 11'd1;
        if (h == H_LAST) v <= v == V_LAST ? '0 : v + 11'd1;
      end
      panel_hsync_n <= ~hs;
      panel_vsync_n <= ~vs;
      panel_de      <= active;
      panel_rgb     <= !active ? '0 : !phase ? pix : panel_rgb;
    end
  end
endmodule

// File: tb/tb_lcd_timing_generator.sv
// tb_lcd_timing_generator: checks lcd_timing_generator on a shrunken raster so whole frames run quickly.
module tb_lcd_timing_generator;
  localparam int HA = 16, HF = 4, HS = 3, HB = 5;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = 2 * HT * VT;
`ifdef LCD_TEST_PATTERN_EN
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif
  typedef struct packed {logic [23:0] rgb; logic de; logic hs_n; logic vs_n;} pan_t;
  typedef struct packed {int c; logic tick; logic de; logic nf; logic pde; logic hs_n; logic vs_n;} vec_t;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        tick, nf, de, pclk, hs_n, vs_n, pde;
  logic [23:0] prgb;
  int          total = 0, bad = 0, cyc = 0;
  logic        rst_q = 1'b1, chk_en = 1'b0;
  pan_t        sb[$];
  vec_t        tbl[16];

  lcd_timing_generator #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clock(clock), .reset(reset),
    .lcd_tick(tick), .lcd_next_frame(nf), .lcd_data_enable(de),
    .lcd_red(red), .lcd_green(green), .lcd_blue(blue),
    .panel_pclk(pclk), .panel_hsync_n(hs_n), .panel_vsync_n(vs_n),
    .panel_de(pde), .panel_rgb(prgb)
  );

  always #5 clock = ~clock;

  // cycles since the last reset edge; raster position is derived from it
  always @(posedge clock) begin
    cyc   <= reset ? 0 : cyc + 1;
    rst_q <= reset;
  end

  function automatic int ph_of(int c); return c % 2; endfunction
  function automatic int h_of(int c); return (c / 2) % HT; endfunction
  function automatic int v_of(int c); return (c / (2 * HT)) % VT; endfunction
  function automatic logic de_of(int c); return h_of(c) < HA && v_of(c) < VA; endfunction
  function automatic logic hs_of(int c); return h_of(c) >= HA + HF && h_of(c) < HA + HF + HS; endfunction
  function automatic logic vs_of(int c); return v_of(c) >= VA + VF && v_of(c) < VA + VF + VS; endfunction
  function automatic logic nf_of(int c); return ph_of(c) == 0 && h_of(c) == 0 && v_of(c) == VA; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    #1 {red, green, blue} = 24'($urandom);
  end

  // per-cycle monitor and panel scoreboard (expected pushed before the edge, popped after it)
  initial begin
    pan_t        prev, e;
    logic [23:0] px;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        check("lcd_outs", 32'({tick, de, nf, pclk}),
              32'({ph_of(cyc) == 1, !reset && de_of(cyc), !reset && nf_of(cyc), !rst_q && ph_of(cyc) == 0}));
        prev = '0;
        if (sb.size() > 0) begin
          prev = sb.pop_front();
          check("panel_sync", 32'({pde, hs_n, vs_n}), 32'({prev.de, prev.hs_n, prev.vs_n}));
          check("panel_rgb", 32'(prgb), 32'(prev.rgb));
        end
`ifdef LCD_TEST_PATTERN_EN
        px = BARS[(h_of(cyc) / (HA / 8)) % 8];
`else
        px = {red, green, blue};
`endif
        if (reset) e = '{rgb: 24'h0, de: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
        else begin
          e.de   = de_of(cyc);
          e.hs_n = !hs_of(cyc);
          e.vs_n = !vs_of(cyc);
          e.rgb  = !e.de ? 24'h0 : ph_of(cyc) == 0 ? px : prev.rgb;
        end
        sb.push_back(e);
      end
    end
  end

  initial begin
    int n, t, c_de, c_nf, c_hs, c_vs;
    //          cyc   tick de nf pde hs vs
    tbl = '{'{1,    1, 1, 0, 1, 1, 1}, '{31,   1, 1, 0, 1, 1, 1},
            '{32,   0, 0, 0, 1, 1, 1}, '{33,   1, 0, 0, 0, 1, 1},
            '{40,   0, 0, 0, 0, 1, 1}, '{41,   1, 0, 0, 0, 0, 1},
            '{46,   0, 0, 0, 0, 0, 1}, '{47,   1, 0, 0, 0, 1, 1},
            '{402,  0, 1, 0, 1, 1, 1}, '{448,  0, 0, 1, 0, 1, 1},
            '{449,  1, 0, 0, 0, 1, 1}, '{561,  1, 0, 0, 0, 1, 0},
            '{671,  1, 0, 0, 0, 1, 0}, '{673,  1, 0, 0, 0, 1, 1},
            '{841,  1, 1, 0, 1, 1, 1}, '{1288, 0, 0, 1, 0, 1, 1}};
    @(posedge clock);
    #1 chk_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("reset_state", 32'({tick, nf, de, pclk, pde, hs_n, vs_n, prgb}), 32'({7'b0000011, 24'h0}));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("tick_release0", 32'(tick), 32'(0));
    @(negedge clock);
    check("tick_release1", 32'(tick), 32'(1));
    foreach (tbl[i]) begin
      n = 0;
      while (cyc != tbl[i].c && n < 3000) begin
        @(negedge clock);
        n++;
      end
      if (n >= 3000) begin
        total++;
        bad++;
        $display("FAIL vec%0d timeout: at cycle %0d want %0d", i, cyc, tbl[i].c);
      end
      check($sformatf("vec%0d", i), 32'({tick, de, nf, pde, hs_n, vs_n}),
            32'({tbl[i].tick, tbl[i].de, tbl[i].nf, tbl[i].pde, tbl[i].hs_n, tbl[i].vs_n}));
    end
    // one-clock reset at v=3, h=7 of the next frame
    t = (cyc / FR + 1) * FR + 2 * (3 * HT + 7);
    n = 0;
    while (cyc != t && n < 2 * FR) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_reset", 32'({tick, de, nf}), 32'(3'b010));
    n = 0;
    while (!nf && n < 2 * FR) begin
      @(negedge clock);
      n++;
    end
    check("nf_after_reset", 32'(n), 32'(2 * HT * VA));
    {c_de, c_nf, c_hs, c_vs} = '0;
    for (int i = 0; i < FR; i++) begin
      c_de += int'(de);
      c_nf += int'(nf);
      c_hs += int'(!hs_n);
      c_vs += int'(!vs_n);
      @(negedge clock);
    end
    check("frame_de", 32'(c_de), 32'(2 * HA * VA));
    check("frame_nf", 32'(c_nf), 32'(1));
    check("frame_hsync", 32'(c_hs), 32'(2 * HS * VT));
    check("frame_vsync", 32'(c_vs), 32'(2 * HT * VS));
    check("nf_period", 32'({nf, tick}), 32'(2'b10));
    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
